// File: rtl/rom_loader_if.sv
// Byte-stream input and ROM write port of the Hack instruction loader.
// slave: the loader side; master: the host link / ROM side.
interface rom_loader_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  rom_we;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_data;

  modport slave (
    input  in_data, in_valid,
    output in_ready, rom_we, rom_addr, rom_data
  );

  modport master (
    output in_data, in_valid,
    input  in_ready, rom_we, rom_addr, rom_data
  );
endinterface

// File: rtl/rom_loader.sv
// rom_loader: receives a length-prefixed big-endian word image as a byte
// stream and writes it sequentially into the instruction ROM from address 0,
// holding the CPU in reset while loading or after an aborted load.
// Optional: define ROM_LOADER_CHECKSUM_EN to require a trailing 8-bit
// checksum byte (sum mod 256 of all data bytes).
module rom_loader #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  rom_loader_if.slave   bus,
  output logic          cpu_reset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERR
`ifdef ROM_LOADER_CHECKSUM_EN
    , CSUM
`endif
  } state_t;

  localparam logic [31:0]           DEPTH    = 32'd1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = 1;

  state_t                state_q, state_d;
  logic [7:0]            len_hi_q, len_hi_d;
  logic [ADDR_WIDTH:0]   n_q, n_d;
  logic [ADDR_WIDTH:0]   wcnt_q, wcnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  in_ready_q, in_ready_d;
  logic                  rom_we_q, rom_we_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  acc;
  logic [31:0]           len_ext;
`ifdef ROM_LOADER_CHECKSUM_EN
  logic [7:0]            csum_q, csum_d;
  state_t                end_st;
  assign end_st = CSUM;
`else
  state_t                end_st;
  assign end_st = DONE;
`endif

  assign acc     = bus.in_valid && in_ready_q;
  assign len_ext = {16'd0, len_hi_q, bus.in_data};

  // Next-state and next-output decode; all outputs are registered from state_d.
  always_comb begin
    state_d  = state_q;
    len_hi_d = len_hi_q;
    n_d      = n_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_d = LEN_HI;
          addr_d  = '0;
          wcnt_d  = '0;
`ifdef ROM_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LEN_HI: if (acc) begin
        len_hi_d = bus.in_data;
        state_d  = LEN_LO;
      end
      LEN_LO: if (acc) begin
        n_d = len_ext[ADDR_WIDTH:0];
        if (len_ext == 32'd0)      state_d = end_st;
        else if (len_ext > DEPTH)  state_d = ERR;
        else                       state_d = DATA_HI;
      end
      DATA_HI: if (acc) begin
        data_d[15:8] = bus.in_data;
`ifdef ROM_LOADER_CHECKSUM_EN
        csum_d = csum_q + bus.in_data;
`endif
        state_d = DATA_LO;
      end
      DATA_LO: if (acc) begin
        data_d[7:0] = bus.in_data;
`ifdef ROM_LOADER_CHECKSUM_EN
        csum_d = csum_q + bus.in_data;
`endif
        state_d = WRITE;
      end
      WRITE: begin
        // Address wraps naturally at 2**ADDR_WIDTH; the count is one bit wider.
        addr_d  = addr_q + ADDR_ONE;
        wcnt_d  = wcnt_q + CNT_ONE;
        state_d = (wcnt_d == n_q) ? end_st : DATA_HI;
      end
`ifdef ROM_LOADER_CHECKSUM_EN
      CSUM: if (acc) state_d = (bus.in_data == csum_q) ? DONE : ERR;
`endif
      default: state_d = IDLE;
    endcase

`ifdef ROM_LOADER_CHECKSUM_EN
    in_ready_d = state_d inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM};
`else
    in_ready_d = state_d inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO};
`endif
    rom_we_d = (state_d == WRITE);
    busy_d   = in_ready_d | rom_we_d;
    done_d   = (state_d == DONE);
    error_d  = (state_d == ERR);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      len_hi_q   <= '0;
      n_q        <= '0;
      wcnt_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      in_ready_q <= 1'b0;
      rom_we_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_hi_q   <= len_hi_d;
      n_q        <= n_d;
      wcnt_q     <= wcnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      in_ready_q <= in_ready_d;
      rom_we_q   <= rom_we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef ROM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.rom_we   = rom_we_q;
  assign bus.rom_addr = addr_q;
  assign bus.rom_data = data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign cpu_reset    = busy_q | error_q;

endmodule

// File: tb/tb_rom_loader.sv
// Directed bench for rom_loader: full-rate, empty, oversize, bursty,
// mid-load reset and (when enabled) checksum loads.
module tb_rom_loader;
  logic clk = 1'b0;
  logic reset_n, start;
  logic cpu_reset, busy, done, error;
  int   total = 0, bad = 0;
  int   wn = 0, viol = 0;
  logic [14:0] w_addr [16];
  logic [15:0] w_data [16];

  rom_loader_if bus ();
  rom_loader dut (.clk(clk), .reset_n(reset_n), .start(start), .bus(bus),
                  .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error));

  always #5 clk = ~clk;

  // Log every ROM write pulse; watch that busy always holds the CPU in reset.
  always @(negedge clk) begin
    if (bus.rom_we && wn < 16) begin
      w_addr[wn] = bus.rom_addr;
      w_data[wn] = bus.rom_data;
      wn++;
    end
    if (busy && !cpu_reset) viol++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    logic acc;
    int   n;
    bus.in_valid = 1'b0;
    repeat (gap) step();
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = bus.in_ready;
      step(); n++;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("send_timeout", 32'(b), 32'hFFFF_FFFF);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (2) step();
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_rom_we", 32'(bus.rom_we), 0);
    check("rst_addr", 32'(bus.rom_addr), 0);
    check("rst_data", 32'(bus.rom_data), 0);
    check("rst_flags", {28'd0, cpu_reset, busy, done, error}, 0);
    reset_n = 1'b1;
    step();

    // Two words at full rate
    wn = 0;
    pulse_start();
    check("t1_busy", {29'd0, busy, cpu_reset, bus.in_ready}, 32'h7);
    send(8'h00, 0); send(8'h02, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0); send(8'hCD, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    send(8'hBE, 0);
`endif
    repeat (2) step();
    check("t1_wn", wn, 2);
    check("t1_a0", 32'(w_addr[0]), 0);
    check("t1_d0", 32'(w_data[0]), 32'h1234);
    check("t1_a1", 32'(w_addr[1]), 1);
    check("t1_d1", 32'(w_data[1]), 32'hABCD);
    check("t1_flags", {28'd0, cpu_reset, busy, done, error}, 32'h2);
    check("t1_addr", 32'(bus.rom_addr), 2);

    // Empty image
    wn = 0;
    pulse_start();
    send(8'h00, 0); send(8'h00, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    check("t2_done", {28'd0, cpu_reset, busy, done, error}, 32'h2);
    step();
    check("t2_wn", wn, 0);
    check("t2_addr", 32'(bus.rom_addr), 0);

    // Oversize length aborts, then a good load recovers
    wn = 0;
    pulse_start();
    send(8'h80, 0); send(8'h01, 0);
    check("t3_err", {27'd0, bus.in_ready, cpu_reset, busy, done, error}, 32'h9);
    step();
    check("t3_wn", wn, 0);
    pulse_start();
    send(8'h00, 0); send(8'h01, 0); send(8'h00, 0); send(8'h07, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    send(8'h07, 0);
`endif
    repeat (2) step();
    check("t3_wn2", wn, 1);
    check("t3_a0", 32'(w_addr[0]), 0);
    check("t3_d0", 32'(w_data[0]), 32'h0007);
    check("t3_flags", {30'd0, done, error}, 32'h2);

    // Bursty source with a stray start pulse mid-load
    wn = 0;
    pulse_start();
    send(8'h00, 2); send(8'h03, 2); send(8'h00, 2); send(8'h01, 2);
    pulse_start();
    check("t4_busy", 32'(busy), 1);
    send(8'h00, 2); send(8'h02, 2); send(8'h00, 2); send(8'h03, 2);
`ifdef ROM_LOADER_CHECKSUM_EN
    send(8'h06, 2);
`endif
    repeat (2) step();
    check("t4_wn", wn, 3);
    check("t4_d0", {w_addr[0], w_data[0]}, {15'd0, 16'h0001});
    check("t4_d1", {w_addr[1], w_data[1]}, {15'd1, 16'h0002});
    check("t4_d2", {w_addr[2], w_data[2]}, {15'd2, 16'h0003});
    check("t4_done", 32'(done), 1);

    // Reset mid-load
    wn = 0;
    pulse_start();
    send(8'h00, 0); send(8'h02, 0); send(8'h12, 0);
    reset_n = 1'b0;
    #1;
    check("t5_flags", {27'd0, bus.in_ready, cpu_reset, busy, done, error}, 0);
    check("t5_bus", {bus.rom_we, bus.rom_addr, bus.rom_data}, 0);
    step();
    reset_n = 1'b1;
    step();
    check("t5_wn", wn, 0);
    pulse_start();
    send(8'h00, 0); send(8'h01, 0); send(8'hBE, 0); send(8'hEF, 0);
`ifdef ROM_LOADER_CHECKSUM_EN
    send(8'hAD, 0);
`endif
    repeat (2) step();
    check("t5_wn2", wn, 1);
    check("t5_d0", {w_addr[0], w_data[0]}, {15'd0, 16'hBEEF});
    check("t5_done", 32'(done), 1);

`ifdef ROM_LOADER_CHECKSUM_EN
    // Checksum match and mismatch
    wn = 0;
    pulse_start();
    send(8'h00, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0); send(8'h46, 0);
    check("t6_ok", {30'd0, done, error}, 32'h2);
    wn = 0;
    pulse_start();
    send(8'h00, 0); send(8'h01, 0); send(8'h12, 0); send(8'h34, 0); send(8'h47, 0);
    check("t6_bad", {29'd0, cpu_reset, done, error}, 32'h5);
    check("t6_wn", wn, 1);
    check("t6_d0", {w_addr[0], w_data[0]}, {15'd0, 16'h1234});
`endif

    check("busy_holds_cpu", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
